// File: rtl/pc_branch_unit_if.sv
// Bus between the decoder (master) and the PC/branch stage (slave).
// pc_en is a single-cycle commit pulse; there is no ready, the stage always accepts it.
interface pc_branch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              pc_en;
    logic [15:0]       instr;
    logic [15:0]       rtarget;
    logic [4:0]        flags_in;
    logic              flags_we;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        psr;
    logic [15:0]       link;
    logic              link_we;
    logic              taken;
    logic              halted;

    modport master (
        output pc_en, instr, rtarget, flags_in, flags_we,
        input  pc, psr, link, link_we, taken, halted
    );

    modport slave (
        input  pc_en, instr, rtarget, flags_in, flags_we,
        output pc, psr, link, link_we, taken, halted
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and PSR stage: advances PC on each decoder commit, resolves
// Bcond/Jcond/JAL against the registered flags, and halts on a branch-to-self.
module pc_branch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset,
    pc_branch_unit_if.slave bus
);
    logic [ADDR_W-1:0] pc_q;
    logic [4:0]        psr_q;
    logic              halted_q;

    logic              is_bcond;
    logic              is_jcond;
    logic              is_jal;
    logic [3:0]        cond;
    logic              c, l, f, z, n;
    logic [15:0]       cond_vec;
    logic              cond_ok;
    logic              taken;
    logic [ADDR_W-1:0] disp;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;

    assign is_bcond = (bus.instr[15:12] == 4'b1100);
    assign is_jcond = (bus.instr[15:12] == 4'b0100) && (bus.instr[7:4] == 4'b1100);
    assign is_jal   = (bus.instr[15:12] == 4'b0100) && (bus.instr[7:4] == 4'b1000);
    assign cond     = bus.instr[11:8];

    // Conditions always look at the registered PSR, never at flags_in.
    assign {c, l, f, z, n} = psr_q;
    // Bit k of cond_vec is the truth of condition code k.
    assign cond_vec = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                       ~n, n, ~l, l, ~c, c, ~z, z};
    assign cond_ok  = cond_vec[cond];

    assign taken    = ((is_bcond || is_jcond) && cond_ok) || is_jal;
    assign disp     = {{(ADDR_W-8){bus.instr[7]}}, bus.instr[7:0]};
    assign pc_plus1 = pc_q + 1'b1;

    always_comb begin
        next_pc = pc_plus1;
        if (taken) begin
            if (is_bcond) next_pc = pc_q + disp;
            else          next_pc = bus.rtarget[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            psr_q    <= 5'b0;
            halted_q <= 1'b0;
        end else begin
            if (bus.flags_we) psr_q <= bus.flags_in;
            if (bus.pc_en && !halted_q) begin
                // A taken transfer that lands on itself can never make progress.
                if (taken && (next_pc == pc_q)) halted_q <= 1'b1;
                else                            pc_q     <= next_pc;
            end
        end
    end

    assign bus.pc      = pc_q;
    assign bus.psr     = psr_q;
    assign bus.halted  = halted_q;
    assign bus.taken   = taken;
    assign bus.link    = 16'(pc_plus1);
    assign bus.link_we = bus.pc_en && is_jal && !halted_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vectors, a per-cycle compare against an
// arithmetic model of the PC/PSR rules, and literal checks of key results.
module tb_pc_branch_unit;
    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] JUC = 16'h4EC0;

    logic clk;
    logic reset;
    bit   run;
    int   tests;
    int   fails;

    pc_branch_unit_if #(.ADDR_W(16)) bus ();

    pc_branch_unit #(.ADDR_W(16), .RESET_PC(16'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int       m_pc     = 0;
    bit [4:0] m_psr    = 5'b0;
    bit       m_halted = 1'b0;
    int       m_next;

    // 0 = no transfer, 1 = Bcond, 2 = Jcond, 3 = JAL
    function automatic int kind_of(logic [15:0] ins);
        if (ins[15:12] == 4'hC) return 1;
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'hC) return 2;
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'h8) return 3;
        return 0;
    endfunction

    function automatic bit cond_holds(int cnd, bit [4:0] p);
        bit cf = p[4];
        bit lf = p[3];
        bit ff = p[2];
        bit zf = p[1];
        bit nf = p[0];
        case (cnd)
            0:  return zf;
            1:  return !zf;
            2:  return cf;
            3:  return !cf;
            4:  return lf;
            5:  return !lf;
            6:  return nf;
            7:  return !nf;
            8:  return ff;
            9:  return !ff;
            10: return !lf && !zf;
            11: return lf || zf;
            12: return !nf && !zf;
            13: return nf || zf;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_taken(logic [15:0] ins, bit [4:0] p);
        int k = kind_of(ins);
        if (k == 3) return 1'b1;
        if (k == 0) return 1'b0;
        return cond_holds(int'(ins[11:8]), p);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc     <= 0;
            m_psr    <= 5'b0;
            m_halted <= 1'b0;
        end else begin
            if (bus.flags_we) m_psr <= bus.flags_in;
            if (bus.pc_en && !m_halted) begin
                if (model_taken(bus.instr, m_psr)) begin
                    if (kind_of(bus.instr) == 1)
                        m_next = (m_pc + int'($signed(bus.instr[7:0]))) & 32'hFFFF;
                    else
                        m_next = int'(bus.rtarget);
                end else begin
                    m_next = (m_pc + 1) & 32'hFFFF;
                end
                if (model_taken(bus.instr, m_psr) && m_next == m_pc) m_halted <= 1'b1;
                else                                                 m_pc     <= m_next;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            check("pc",      32'(bus.pc),      32'(m_pc));
            check("psr",     32'(bus.psr),     32'(m_psr));
            check("halted",  32'(bus.halted),  32'(m_halted));
            check("link",    32'(bus.link),    (m_pc + 1) & 32'hFFFF);
            check("taken",   32'(bus.taken),   32'(model_taken(bus.instr, m_psr)));
            check("link_we", 32'(bus.link_we),
                  32'(bus.pc_en && kind_of(bus.instr) == 3 && !m_halted));
        end
    end

    // ---------------- driver ----------------
    task automatic set_in(input logic en, input logic [15:0] ins, input logic [15:0] rt,
                          input logic [4:0] fi, input logic fwe);
        bus.pc_en    = en;
        bus.instr    = ins;
        bus.rtarget  = rt;
        bus.flags_in = fi;
        bus.flags_we = fwe;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [15:0] t);
        set_in(1'b1, JUC, t, 5'b0, 1'b0);
        commit();
    endtask

    initial begin
        run   = 1'b0;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        set_in(1'b0, NOP, 16'h0, 5'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run = 1'b1;
        check("reset_pc", 32'(bus.pc), 32'h0);
        check("reset_psr", 32'(bus.psr), 32'h0);
        check("reset_halted", 32'(bus.halted), 32'h0);

        // Sequential NOPs.
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, NOP, 16'h0, 5'b0, 1'b0);
            check("nop_link", 32'(bus.link), 32'(i));
            commit();
            check("nop_pc", 32'(bus.pc), 32'(i));
        end

        // Bcond EQ / NE with Z=1.
        jump_to(16'd10);
        set_in(1'b0, NOP, 16'h0, 5'b00010, 1'b1);
        commit();
        set_in(1'b1, 16'hC0FC, 16'h0, 5'b0, 1'b0);
        check("beq_taken", 32'(bus.taken), 32'h1);
        commit();
        check("beq_pc", 32'(bus.pc), 32'd6);
        jump_to(16'd10);
        set_in(1'b1, 16'hC1FC, 16'h0, 5'b0, 1'b0);
        commit();
        check("bne_pc", 32'(bus.pc), 32'd11);

        // Wrap-around both ways.
        jump_to(16'hFFFF);
        set_in(1'b1, NOP, 16'h0, 5'b0, 1'b0);
        commit();
        check("wrap_up_pc", 32'(bus.pc), 32'h0);
        set_in(1'b1, 16'hCEFF, 16'h0, 5'b0, 1'b0);
        commit();
        check("wrap_down_pc", 32'(bus.pc), 32'hFFFF);
        check("wrap_down_halted", 32'(bus.halted), 32'h0);

        // JAL and Jcond FS with F=0.
        jump_to(16'd5);
        set_in(1'b1, 16'h4383, 16'h0040, 5'b0, 1'b0);
        check("jal_link", 32'(bus.link), 32'd6);
        check("jal_link_we", 32'(bus.link_we), 32'h1);
        commit();
        check("jal_pc", 32'(bus.pc), 32'h40);
        set_in(1'b1, 16'h48C0, 16'h0099, 5'b0, 1'b0);
        check("jfs_link_we", 32'(bus.link_we), 32'h0);
        commit();
        check("jfs_pc", 32'(bus.pc), 32'h41);

        // Same-edge flags write: branch sees old PSR.
        set_in(1'b0, NOP, 16'h0, 5'b0, 1'b1);
        commit();
        set_in(1'b1, 16'hC004, 16'h0, 5'b00010, 1'b1);
        check("same_edge_taken", 32'(bus.taken), 32'h0);
        commit();
        check("same_edge_pc", 32'(bus.pc), 32'h42);
        set_in(1'b1, 16'hC004, 16'h0, 5'b0, 1'b0);
        check("next_beq_taken", 32'(bus.taken), 32'h1);
        commit();
        check("next_beq_pc", 32'(bus.pc), 32'h46);

        // Branch-to-self halts; halt is sticky.
        jump_to(16'd20);
        set_in(1'b1, 16'hCE00, 16'h0, 5'b0, 1'b0);
        commit();
        check("halt_set", 32'(bus.halted), 32'h1);
        check("halt_pc", 32'(bus.pc), 32'd20);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, (i % 2 == 0) ? NOP : 16'h4383, 16'h0040, 5'b0, 1'b0);
            commit();
            check("halt_hold_pc", 32'(bus.pc), 32'd20);
        end

        // Reset mid-cycle with a pending commit.
        set_in(1'b1, NOP, 16'h0, 5'b0, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("midreset_pc", 32'(bus.pc), 32'h0);
        check("midreset_halted", 32'(bus.halted), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        check("post_reset_pc", 32'(bus.pc), 32'h0);
        set_in(1'b1, NOP, 16'h0, 5'b0, 1'b0);
        commit();
        check("post_reset_step", 32'(bus.pc), 32'h1);

        // Every condition code against a spread of PSR values.
        for (int fv = 0; fv < 32; fv++) begin
            set_in(1'b0, NOP, 16'h0, 5'(fv), 1'b1);
            commit();
            for (int cc = 0; cc < 16; cc++) begin
                set_in(1'b0, {4'hC, 4'(cc), 8'h10}, 16'h0, 5'b0, 1'b0);
                commit();
            end
        end

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
